// File: rtl/rec_mult_pkg.sv
// Shared definitions for the sequential recursive multiplier: mode encoding,
// controller state enum and the partial-product skip predicate.
package rec_mult_pkg;

  localparam logic [1:0] MODE_EXACT  = 2'd0;
  localparam logic [1:0] MODE_APPROX = 2'd1;
  localparam logic [1:0] MODE_SKIP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Low-significance products (i+j < k-1) are dropped in skip mode.
  function automatic logic skip_product(input logic [1:0] mode,
                                        input int unsigned i,
                                        input int unsigned j,
                                        input int unsigned k);
    return (mode >= MODE_SKIP) && ((i + j + 32'd1) < k);
  endfunction

  // Mode 3 is an alias of the skip mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_SKIP : mode;
  endfunction

endpackage

// File: rtl/rec_mult_core.sv
// Combinational N x N recursive multiplier; the 2x2 leaf optionally returns
// 7 for 3*3, and every level above recombines four half-width products exactly.
module rec_mult_core #(
  parameter int N = 8
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic           approx,
  output logic [2*N-1:0] p
);

  generate
    if (N == 2) begin : g_leaf
      // 2x2 cell with the single approximate entry.
      always_comb begin
        if (approx && (x == 2'd3) && (y == 2'd3)) begin
          p = 4'd7;
        end else begin
          p = {2'b00, x} * {2'b00, y};
        end
      end
    end else begin : g_split
      localparam int H = N / 2;
      logic [N-1:0] hh_s, hl_s, lh_s, ll_s;

      rec_mult_core #(.N(H)) u_hh (.x(x[N-1:H]), .y(y[N-1:H]), .approx(approx), .p(hh_s));
      rec_mult_core #(.N(H)) u_hl (.x(x[N-1:H]), .y(y[H-1:0]), .approx(approx), .p(hl_s));
      rec_mult_core #(.N(H)) u_lh (.x(x[H-1:0]), .y(y[N-1:H]), .approx(approx), .p(lh_s));
      rec_mult_core #(.N(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .approx(approx), .p(ll_s));

      // Exact shifted recombination; the approximate sum never exceeds the exact one.
      always_comb begin
        p = {hh_s, {N{1'b0}}}
          + {{H{1'b0}}, hl_s, {H{1'b0}}}
          + {{H{1'b0}}, lh_s, {H{1'b0}}}
          + {{N{1'b0}}, ll_s};
      end
    end
  endgenerate

endmodule

// File: rtl/rec_mult_seq.sv
// Multi-cycle multiplier that time-shares one BASE_W recursive core over all
// K*K chunk products and accumulates them behind valid/ready handshakes.
module rec_mult_seq
  import rec_mult_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BASE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_y,
  output logic [1:0]         out_mode
);

  localparam int unsigned K     = WIDTH / BASE_W;
  localparam int unsigned NPROD = K * K;
  localparam int          IDXW  = (NPROD > 1) ? $clog2(NPROD) : 1;
  localparam int          PW    = 2 * WIDTH;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPROD - 1);

  state_e              state_r;
  logic [WIDTH-1:0]    a_r, b_r;
  logic [1:0]          mode_r;
  logic [IDXW-1:0]     idx_r;
  logic [PW-1:0]       acc_r;

  int unsigned         i_s, j_s;
  logic [BASE_W-1:0]   a_chunk_s, b_chunk_s;
  logic [2*BASE_W-1:0] core_p_s;
  logic [PW-1:0]       term_s;
  logic                approx_s;

  // Chunk select for the current product index and its shifted contribution.
  always_comb begin
    i_s       = 32'(idx_r) / K;
    j_s       = 32'(idx_r) % K;
    a_chunk_s = BASE_W'(a_r >> (i_s * BASE_W));
    b_chunk_s = BASE_W'(b_r >> (j_s * BASE_W));
    approx_s  = (mode_r != MODE_EXACT);
    if (skip_product(mode_r, i_s, j_s, K)) begin
      term_s = {PW{1'b0}};
    end else begin
      term_s = PW'(core_p_s) << ((i_s + j_s) * BASE_W);
    end
  end

  rec_mult_core #(.N(BASE_W)) u_core (
    .x      (a_chunk_s),
    .y      (b_chunk_s),
    .approx (approx_s),
    .p      (core_p_s)
  );

  // Controller, operand/index/accumulator registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      mode_r    <= MODE_EXACT;
      idx_r     <= {IDXW{1'b0}};
      acc_r     <= {PW{1'b0}};
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= {PW{1'b0}};
      out_mode  <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            mode_r   <= norm_mode(in_mode);
            acc_r    <= {PW{1'b0}};
            idx_r    <= {IDXW{1'b0}};
            in_ready <= 1'b0;
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          acc_r <= acc_r + term_s;
          idx_r <= idx_r + IDXW'(1);
          if (idx_r == LAST_IDX) begin
            idx_r     <= {IDXW{1'b0}};
            out_y     <= acc_r + term_s;
            out_mode  <= mode_r;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
